seq_bin2bcd_dd: RTL
===================

// Module: seq_bin2bcd_dd
// PURPOSE
//  Iterative double-dabble binary-to-BCD converter, parametrised in input width and digit count.
//  Each clock it applies the per-nibble add-3 correction (+3 when digit >= 5) to every BCD digit in parallel, then shifts.
//  Accepts a start pulse and returns a registered BCD result with a done pulse.
//  Feeds display/print paths that currently use fixed-width combinational converters.
// PARAMETERS
//  BIN_W       8   width of binary input; iterations per conversion = BIN_W
//  BCD_DIGITS  3   number of BCD output digits; must be >= 1
// PORTS
//  clk       in   1             rising-edge clock
//  rst_n     in   1             asynchronous active-low reset
//  start     in   1             request; sampled only while idle (busy=0)
//  bin_in    in   BIN_W         operand; sampled on the accepting edge only
//  busy      out  1             conversion in progress
//  done      out  1             one-cycle pulse: bcd_out/overflow valid and updated
//  bcd_out   out  4*BCD_DIGITS  packed BCD result, digit 0 in [3:0]
//  overflow  out  1             result exceeded BCD_DIGITS digits; bcd_out holds the low digits
//  sign      out  1             present only with DD_SIGNED_EN; 1 = negative operand
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, busy=0, done=0, bcd_out=0, overflow=0, sign=0, internal regs=0.
//  - Reset asserted mid-conversion aborts it; no done is produced; outputs return to reset values.
//  - FSM: IDLE -> RUN on the edge with start=1 in IDLE; RUN -> IDLE after BIN_W steps.
//  - Accept edge E0: load bin reg <= operand, digit reg <= 0, ovf_sticky <= 0, count <= 0, busy <= 1.
//  - Each edge E1..E_BIN_W in RUN, one step:
//    digit d' = d + 3 if d >= 5 else d, for every digit (4-bit add, no carry between digits);
//    then {digits, bin} shifted left 1;
//    bit leaving the top digit ORed into ovf_sticky.
//  - On edge E_BIN_W: bcd_out <= final digits, overflow <= sticky (including this step's bit),
//    done <= 1, busy <= 0, state <= IDLE.
//  - Latency: done is high in the cycle after E_BIN_W, i.e. BIN_W edges after the accept edge.
//  - done is high exactly one cycle; bcd_out/overflow/sign hold until the next completion.
//  - start while busy=1 is ignored (not queued); bin_in changes while busy have no effect.
//  - start=1 during the done cycle is accepted (state already IDLE); back-to-back throughput = one result per BIN_W+1 cycles.
//  - start held high continuously: a new conversion starts every BIN_W+1 cycles.
//  - Width rule: internal shift reg is 4*BCD_DIGITS+BIN_W bits; count width = clog2(BIN_W+1).
//  - BIN_W=1 legal: single step, done 1 edge after accept.
// CONFIGURATION
//  - Macro DD_SIGNED_EN defined:
//    bin_in is two's complement;
//    at accept, magnitude = bin_in[BIN_W-1] ? -bin_in : bin_in, computed BIN_W bits wide, unsigned (-2^(BIN_W-1) -> 2^(BIN_W-1));
//    sign port exists and is registered with bcd_out at completion;
//    zero gives sign=0.
//  - Not defined: bin_in is unsigned; sign port and negation logic are absent; all other timing is identical.
// TESTING
//  1. BIN_W=8,D=3: reset, start with bin_in=8'd255 -> done high exactly 8 edges after accept, bcd_out=12'h255, overflow=0.
//  2. bin_in=0 -> bcd_out=12'h000.
//     Exhaustive 0..255 vs reference model: every result matches, done width is 1 cycle.
//  3. Accept 8'd99, pulse start with 8'd7 at step 3 -> result 12'h099, only one done.
//     Then start during the done cycle with 8'd7 -> next done 9 cycles later, bcd_out=12'h007.
//  4. BIN_W=8,D=2: 8'd255 -> bcd_out=8'h55, overflow=1; 8'd99 -> 8'h99, overflow=0.
//  5. Assert rst_n=0 at step 4 of 8'd200, release, then idle 10 cycles -> no done, bcd_out=0, busy=0.
//     Next 8'd200 -> 12'h200.
//  6. DD_SIGNED_EN, BIN_W=8: 8'h80 -> sign=1, bcd_out=12'h128; 8'hFF -> sign=1, 12'h001; 8'h7F -> sign=0, 12'h127.

Source files
------------

// File: rtl/seq_bin2bcd_dd.sv
// Iterative double-dabble binary-to-BCD converter: one add-3/shift step per clock, BIN_W steps per result.
// Optional feature macro: DD_SIGNED_EN (two's-complement operand, adds the sign output).
module seq_bin2bcd_dd #(
    parameter int BIN_W      = 8,
    parameter int BCD_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin_in,
    output logic                    busy,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd_out,
    output logic                    overflow
`ifdef DD_SIGNED_EN
    ,
    output logic                    sign
`endif
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = (BIN_W + 1 > 1) ? $clog2(BIN_W + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [BIN_W-1:0]   bin_reg;
    logic [BCD_W-1:0]   digit_reg;
    logic               ovf_sticky_reg;
    logic [CNT_W-1:0]   count_reg;

    logic               accept;
    logic               last_step;
    logic [BIN_W-1:0]   operand;
    logic [BCD_W-1:0]   digit_adj;
    logic [SR_W-1:0]    shift_next;
    logic               bit_out;

`ifdef DD_SIGNED_EN
    logic               sign_pend_reg;
    logic               operand_neg;

    // Magnitude stays BIN_W bits unsigned, so the most negative value maps to 2^(BIN_W-1).
    assign operand_neg = bin_in[BIN_W-1];
    assign operand     = operand_neg ? (~bin_in + BIN_W'(1)) : bin_in;
`else
    assign operand     = bin_in;
`endif

    assign accept    = (state_reg == IDLE) && start;
    assign last_step = (state_reg == RUN) && (count_reg == LAST_STEP);
    assign busy      = (state_reg == RUN);

    // Per-digit add-3 correction; no carry propagates between digits.
    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
            assign digit_adj[4*gi +: 4] = (digit_reg[4*gi +: 4] >= 4'd5)
                                          ? (digit_reg[4*gi +: 4] + 4'd3)
                                          : digit_reg[4*gi +: 4];
        end
    endgenerate

    assign bit_out    = digit_adj[BCD_W-1];
    assign shift_next = {digit_adj[BCD_W-2:0], bin_reg, 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (count_reg == LAST_STEP) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_reg        <= '0;
            digit_reg      <= '0;
            ovf_sticky_reg <= 1'b0;
            count_reg      <= '0;
            done           <= 1'b0;
            bcd_out        <= '0;
            overflow       <= 1'b0;
`ifdef DD_SIGNED_EN
            sign_pend_reg  <= 1'b0;
            sign           <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (accept) begin
                bin_reg        <= operand;
                digit_reg      <= '0;
                ovf_sticky_reg <= 1'b0;
                count_reg      <= '0;
`ifdef DD_SIGNED_EN
                sign_pend_reg  <= operand_neg;
`endif
            end else if (state_reg == RUN) begin
                digit_reg      <= shift_next[SR_W-1:BIN_W];
                bin_reg        <= shift_next[BIN_W-1:0];
                ovf_sticky_reg <= ovf_sticky_reg | bit_out;
                count_reg      <= count_reg + CNT_W'(1);
                if (last_step) begin
                    // Publish including the bit shifted out on this final step.
                    bcd_out  <= shift_next[SR_W-1:BIN_W];
                    overflow <= ovf_sticky_reg | bit_out;
                    done     <= 1'b1;
`ifdef DD_SIGNED_EN
                    sign     <= sign_pend_reg;
`endif
                end
            end
        end
    end

endmodule
